// File: rtl/demux4_serializer.sv
`default_nettype none
// ============================================================================
// Module      : demux4_serializer
// Description : Upstream driver for a 1-to-4 dataflow demux. Accepts a frame
//               of four channel words over valid/ready, then shifts each word
//               out MSB-first on d with {s1,s0} carrying the channel index.
//               It also provides a bit strobe, a last-bit flag and a
//               frame-done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module demux4_serializer #(
  parameter int WIDTH = 8,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] ch0_data,
  input  logic [WIDTH-1:0] ch1_data,
  input  logic [WIDTH-1:0] ch2_data,
  input  logic [WIDTH-1:0] ch3_data,
  output logic             d,
  output logic             s1,
  output logic             s0,
  output logic             bit_strobe,
  output logic             ch_last,
  output logic             busy,
  output logic             frame_done
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

  localparam logic [BW-1:0] C_BIT_TOP  = BW'(WIDTH - 1);
  localparam logic [BW-1:0] C_BIT_ONE  = BW'(1);
  localparam logic [GW-1:0] C_GAP_TOP  = GW'((GAP > 0) ? (GAP - 1) : 0);
  localparam logic [GW-1:0] C_GAP_ONE  = GW'(1);
  // A one-bit word makes its first bit also its last bit.
  localparam logic          C_FIRST_IS_LAST = (WIDTH == 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] sh_q [4];
  logic [1:0]       ch_q;
  logic [BW-1:0]    bit_cnt_q;
  logic [GW-1:0]    gap_cnt_q;

  logic             d_q;
  logic [1:0]       sel_q;
  logic             strobe_q;
  logic             last_q;
  logic             busy_q;
  logic             done_q;
  logic             ready_q;

  logic [1:0]       ch_next_d;
  logic [BW-1:0]    bit_next_d;
  logic             shift_bit_d;
  logic             next_ch_bit_d;

  // Look-ahead values so every output can be registered on the edge that
  // enters the cycle in which it is shown.
  assign ch_next_d     = ch_q + 2'd1;
  assign bit_next_d    = bit_cnt_q - C_BIT_ONE;
  assign shift_bit_d   = sh_q[ch_q][bit_next_d];
  assign next_ch_bit_d = sh_q[ch_next_d][C_BIT_TOP];

  // Frame sequencer: state, shadow words, counters and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      for (int i = 0; i < 4; i++) sh_q[i] <= '0;
      ch_q      <= 2'd0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      d_q       <= 1'b0;
      sel_q     <= 2'd0;
      strobe_q  <= 1'b0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (in_valid) begin
            sh_q[0]   <= ch0_data;
            sh_q[1]   <= ch1_data;
            sh_q[2]   <= ch2_data;
            sh_q[3]   <= ch3_data;
            ch_q      <= 2'd0;
            bit_cnt_q <= C_BIT_TOP;
            state_q   <= S_SHIFT;
            // Shadow is loaded on this same edge, so take bit straight from input.
            d_q       <= ch0_data[WIDTH-1];
            sel_q     <= 2'd0;
            strobe_q  <= 1'b1;
            last_q    <= C_FIRST_IS_LAST;
            busy_q    <= 1'b1;
            ready_q   <= 1'b0;
            done_q    <= 1'b0;
          end else begin
            state_q   <= S_IDLE;
            d_q       <= 1'b0;
            strobe_q  <= 1'b0;
            last_q    <= 1'b0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
          end
        end

        S_SHIFT: begin
          if (bit_cnt_q != '0) begin
            bit_cnt_q <= bit_next_d;
            d_q       <= shift_bit_d;
            last_q    <= (bit_cnt_q == C_BIT_ONE);
          end else if (ch_q == 2'd3) begin
            state_q   <= S_DONE;
            d_q       <= 1'b0;
            strobe_q  <= 1'b0;
            last_q    <= 1'b0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b1;
            done_q    <= 1'b1;
          end else if (GAP > 0) begin
            state_q   <= S_GAP;
            gap_cnt_q <= C_GAP_TOP;
            d_q       <= 1'b0;
            strobe_q  <= 1'b0;
            last_q    <= 1'b0;
          end else begin
            ch_q      <= ch_next_d;
            bit_cnt_q <= C_BIT_TOP;
            d_q       <= next_ch_bit_d;
            sel_q     <= ch_next_d;
            last_q    <= C_FIRST_IS_LAST;
          end
        end

        S_GAP: begin
          if (gap_cnt_q != '0) begin
            gap_cnt_q <= gap_cnt_q - C_GAP_ONE;
          end else begin
            state_q   <= S_SHIFT;
            ch_q      <= ch_next_d;
            bit_cnt_q <= C_BIT_TOP;
            d_q       <= next_ch_bit_d;
            sel_q     <= ch_next_d;
            strobe_q  <= 1'b1;
            last_q    <= C_FIRST_IS_LAST;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready   = ready_q;
  assign d          = d_q;
  assign s1         = sel_q[1];
  assign s0         = sel_q[0];
  assign bit_strobe = strobe_q;
  assign ch_last    = last_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_demux4_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_demux4_serializer
// Description : Self-checking bench for demux4_serializer. Two instances:
//               A (WIDTH=8, GAP=1) and B (WIDTH=4, GAP=0). Expected output
//               streams are built per frame from the serialisation rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demux4_serializer;

  localparam int WA = 8;
  localparam int GA = 1;
  localparam int WB = 4;
  localparam int GB = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic          a_valid, a_ready, a_d, a_s1, a_s0, a_stb, a_last, a_busy, a_fd;
  logic [WA-1:0] a_w0, a_w1, a_w2, a_w3;
  logic          b_valid, b_ready, b_d, b_s1, b_s0, b_stb, b_last, b_busy, b_fd;
  logic [WB-1:0] b_w0, b_w1, b_w2, b_w3;

  int checks   = 0;
  int failures = 0;

  demux4_serializer #(.WIDTH(WA), .GAP(GA)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_valid), .in_ready(a_ready),
    .ch0_data(a_w0), .ch1_data(a_w1), .ch2_data(a_w2), .ch3_data(a_w3),
    .d(a_d), .s1(a_s1), .s0(a_s0), .bit_strobe(a_stb), .ch_last(a_last),
    .busy(a_busy), .frame_done(a_fd)
  );

  demux4_serializer #(.WIDTH(WB), .GAP(GB)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_valid), .in_ready(b_ready),
    .ch0_data(b_w0), .ch1_data(b_w1), .ch2_data(b_w2), .ch3_data(b_w3),
    .d(b_d), .s1(b_s1), .s0(b_s0), .bit_strobe(b_stb), .ch_last(b_last),
    .busy(b_busy), .frame_done(b_fd)
  );

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // Output bundle: {d, s1, s0, bit_strobe, ch_last, busy, in_ready, frame_done}
  function automatic logic [7:0] obs(input int sel);
    if (sel == 0) return {a_d, a_s1, a_s0, a_stb, a_last, a_busy, a_ready, a_fd};
    return {b_d, b_s1, b_s0, b_stb, b_last, b_busy, b_ready, b_fd};
  endfunction

  task automatic set_inputs(input int sel, input logic v, input int w[4]);
    if (sel == 0) begin
      a_valid = v; a_w0 = WA'(w[0]); a_w1 = WA'(w[1]); a_w2 = WA'(w[2]); a_w3 = WA'(w[3]);
    end else begin
      b_valid = v; b_w0 = WB'(w[0]); b_w1 = WB'(w[1]); b_w2 = WB'(w[2]); b_w3 = WB'(w[3]);
    end
  endtask

  task automatic rand_words(output int w[4]);
    for (int i = 0; i < 4; i++) w[i] = int'($urandom_range(0, 255));
  endtask

  // Present a frame for exactly one accepting edge, then scramble the inputs.
  task automatic offer(input int sel, input int w[4]);
    int junk[4];
    @(negedge clk);
    set_inputs(sel, 1'b1, w);
    @(posedge clk);
    #1;
    rand_words(junk);
    set_inputs(sel, 1'b0, junk);
  endtask

  // Builds the expected per-cycle stream of one frame (bits, gaps, done
  // cycle) and compares the first n_limit cycles starting at the next negedge.
  task automatic check_frame(input int sel, input int w[4], input int n_limit, input string tag);
    int W = (sel == 0) ? WA : WB;
    int G = (sel == 0) ? GA : GB;
    logic [7:0] exp_q[$];
    logic [1:0] s;
    logic       bitv;
    logic [7:0] o;
    int n, strobes, lasts, first_i, last_i;
    for (int c = 0; c < 4; c++) begin
      s = 2'(c);
      for (int b = W - 1; b >= 0; b--) begin
        bitv = ((w[c] >> b) & 1) != 0;
        exp_q.push_back({bitv, s, 1'b1, (b == 0), 1'b1, 1'b0, 1'b0});
      end
      if (c < 3)
        for (int g = 0; g < G; g++) exp_q.push_back({1'b0, s, 5'b00100});
    end
    exp_q.push_back({1'b0, 2'b11, 5'b00011});
    n = (n_limit < exp_q.size()) ? n_limit : exp_q.size();
    strobes = 0; lasts = 0; first_i = -1; last_i = -1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      o = obs(sel);
      chk($sformatf("%s[%0d]", tag, i), o, exp_q[i]);
      if (o[4]) begin
        strobes++;
        if (first_i < 0) first_i = i;
        last_i = i;
      end
      if (o[3]) lasts++;
    end
    if (n == exp_q.size()) begin
      chk({tag, "_strobes"}, strobes, 4 * W);
      chk({tag, "_lasts"}, lasts, 4);
      chk({tag, "_span"}, last_i - first_i + 1, 4 * W + 3 * G);
    end
  endtask

  task automatic check_idle(input int sel, input int n, input logic [1:0] s, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk($sformatf("%s[%0d]", tag, i), obs(sel), {1'b0, s, 5'b00010});
    end
  endtask

  initial begin
    int f[4], g[4], h[4];
    rst_n = 1'b0;
    f = '{0, 0, 0, 0};
    set_inputs(0, 1'b0, f);
    set_inputs(1, 1'b0, f);

    // Reset state, then release
    #12;
    chk("rst_a", obs(0), 8'h02);
    chk("rst_b", obs(1), 8'h02);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_idle(0, 2, 2'b00, "idle_a");
    check_idle(1, 2, 2'b00, "idle_b");

    // Directed frame on A
    f = '{'hA5, 'h3C, 'hFF, 'h00};
    offer(0, f);
    check_frame(0, f, 1000, "t2");
    check_idle(0, 2, 2'b11, "t2_idle");

    // in_valid held high: second frame accepted in the done cycle
    rand_words(g);
    rand_words(h);
    @(negedge clk);
    set_inputs(0, 1'b1, g);
    @(posedge clk);
    #1;
    set_inputs(0, 1'b1, h);
    check_frame(0, g, 1000, "t3a");
    @(posedge clk);
    #1;
    rand_words(f);
    set_inputs(0, 1'b0, f);
    check_frame(0, h, 1000, "t3b");
    check_idle(0, 2, 2'b11, "t3_idle");

    // Reset during ch2 bit 4 (cycle 21 of the frame)
    rand_words(f);
    offer(0, f);
    check_frame(0, f, 22, "t4");
    #2;
    rst_n = 1'b0;
    #1;
    chk("t4_async", obs(0), 8'h02);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_idle(0, 4, 2'b00, "t4_idle");

    // Directed frame on B (WIDTH=4, GAP=0)
    f = '{'h9, 'h6, 'hF, 'h1};
    offer(1, f);
    check_frame(1, f, 1000, "t5");
    check_idle(1, 1, 2'b11, "t5_idle");

    // Random frames on both instances
    for (int k = 0; k < 6; k++) begin
      for (int sel = 0; sel < 2; sel++) begin
        rand_words(f);
        offer(sel, f);
        check_frame(sel, f, 1000, $sformatf("rnd%0d_%0d", k, sel));
        check_idle(sel, int'($urandom_range(1, 3)), 2'b11, $sformatf("rnd%0d_%0d_idle", k, sel));
      end
    end

    // Back-to-back on B with in_valid held
    rand_words(g);
    rand_words(h);
    @(negedge clk);
    set_inputs(1, 1'b1, g);
    @(posedge clk);
    #1;
    set_inputs(1, 1'b1, h);
    check_frame(1, g, 1000, "b2b_a");
    @(posedge clk);
    #1;
    rand_words(f);
    set_inputs(1, 1'b0, f);
    check_frame(1, h, 1000, "b2b_b");
    check_idle(1, 2, 2'b11, "b2b_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
